// File: rtl/fifo_axis_drain.sv
// rtl/fifo_axis_drain.sv - FIFO-to-AXI-Stream drain with 2-entry skid buffer and burst tlast
// Optional macro FIFO_AXIS_DRAIN_STATS_EN adds saturating beat_cnt/burst_cnt outputs.
module fifo_axis_drain #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              rstp,
    input  logic              en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_emptyp,
    output logic              fifo_readp,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
`ifdef FIFO_AXIS_DRAIN_STATS_EN
    output logic [15:0]       beat_cnt,
    output logic [15:0]       burst_cnt,
`endif
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    logic [1:0]        occ;
    logic              rd_pend;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic              pop;
    logic [2:0]        fill;
    logic              cap_hi;

    assign pop  = m_tvalid & m_tready;
    assign fill = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};

    // Credit rule: count the in-flight read so the buffer can never overflow.
    assign fifo_readp = en & ~fifo_emptyp & ~rstp & (fill < 3'd2);

    // Capture slot is occ - pop; a pending read guarantees occ <= 1.
    assign cap_hi = ((occ == 2'd1) & ~pop) | ((occ == 2'd2) & pop);

    assign m_tvalid = (occ != 2'd0);
    assign m_tdata  = entry0;
    assign m_tlast  = m_tvalid & (cnt == LAST_CNT);
    assign busy     = (occ != 2'd0) | rd_pend;

    always_ff @(posedge clk) begin
        if (rstp) begin
            occ     <= 2'd0;
            rd_pend <= 1'b0;
            cnt     <= '0;
            entry0  <= '0;
            entry1  <= '0;
        end else begin
            occ     <= fill[1:0];
            rd_pend <= fifo_readp;
            if (pop) begin
                entry0 <= entry1;
                cnt    <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            end
            // Capture after the shift so a simultaneous pop/capture lands in entry0.
            if (rd_pend) begin
                if (cap_hi) begin
                    entry1 <= fifo_dout;
                end else begin
                    entry0 <= fifo_dout;
                end
            end
        end
    end

`ifdef FIFO_AXIS_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rstp) begin
            beat_cnt  <= 16'h0000;
            burst_cnt <= 16'h0000;
        end else begin
            if (pop && beat_cnt != 16'hFFFF) begin
                beat_cnt <= beat_cnt + 16'h0001;
            end
            if (pop && m_tlast && burst_cnt != 16'hFFFF) begin
                burst_cnt <= burst_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// tb/tb_fifo_axis_drain.sv - scoreboard bench for fifo_axis_drain with a behavioural FIFO model
module tb_fifo_axis_drain;

    logic        clk = 1'b0;
    logic        rstp;
    logic        en;
    logic [15:0] fifo_dout;
    logic        fifo_emptyp;
    logic        fifo_readp;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
`ifdef FIFO_AXIS_DRAIN_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] burst_cnt;
`endif

    fifo_axis_drain #(.DATA_W(16), .BURST_LEN(4), .CNT_W(2)) dut (
        .clk         (clk),
        .rstp        (rstp),
        .en          (en),
        .fifo_dout   (fifo_dout),
        .fifo_emptyp (fifo_emptyp),
        .fifo_readp  (fifo_readp),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
`ifdef FIFO_AXIS_DRAIN_STATS_EN
        .beat_cnt    (beat_cnt),
        .burst_cnt   (burst_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          s_cyc;
    logic [15:0] fq[$];
    logic [15:0] exp_q[$];
    int          mcnt = 0;
    logic        s_readp, s_pop, s_valid, s_last, s_busy, s_empty;
    logic [15:0] s_data;
    logic        stall_prev = 1'b0;
    logic [15:0] data_prev = 16'h0;
    logic [15:0] last_tlast_data = 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_emptyp = 1'b0;
    endtask

    // One clock: sample/check at negedge, then update the FIFO model just after posedge.
    task automatic step();
        logic [15:0] e;
        @(negedge clk);
        s_cyc   = cyc;
        s_readp = fifo_readp;
        s_pop   = m_tvalid & m_tready;
        s_valid = m_tvalid;
        s_last  = m_tlast;
        s_busy  = busy;
        s_data  = m_tdata;
        s_empty = fifo_emptyp;
        if (s_empty) check("rd_while_empty", s_readp, 1'b0);
        if (stall_prev) begin
            check("hold_valid", s_valid, 1'b1);
            check("hold_data", s_data, data_prev);
        end
        stall_prev = m_tvalid & ~m_tready & ~rstp;
        data_prev  = m_tdata;
        if (s_pop) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", s_data, e);
                check("beat_last", s_last, (mcnt == 3));
                mcnt = (mcnt + 1) % 4;
                if (s_last) last_tlast_data = s_data;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_readp && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_emptyp = (fq.size() == 0);
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        step();
        while ((exp_q.size() != 0 || s_busy) && k < maxc) begin
            step();
            k++;
        end
        if (k >= maxc) check("drain_timeout", 1, 0);
    endtask

    initial begin
        int c0, c1, prev, nb, nlast, nrd, k;
        rstp = 1'b1; en = 1'b0; m_tready = 1'b0;
        fifo_dout = 16'h0; fifo_emptyp = 1'b1;
        step(); step();
        rstp = 1'b0;

        // Reset state and idle with an empty FIFO.
        en = 1'b1;
        step();
        check("rst_valid", s_valid, 1'b0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_data", s_data, 16'h0000);
        check("rst_last", s_last, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_readp", s_readp, 1'b0);
            check("idle_valid", s_valid, 1'b0);
        end

        // Streaming 8 words at full rate.
        m_tready = 1'b1;
        for (int i = 1; i <= 8; i++) push(16'(i));
        c0 = -1; c1 = -1; prev = -1; nb = 0; nlast = 0; k = 0;
        while (nb < 8 && k < 40) begin
            step();
            k++;
            if (s_readp && c0 < 0) c0 = s_cyc;
            if (s_pop) begin
                if (c1 < 0) c1 = s_cyc;
                if (prev >= 0) check("stream_gap", s_cyc - prev, 1);
                prev = s_cyc;
                nb++;
                if (s_last) nlast++;
            end
        end
        check("stream_beats", nb, 8);
        check("first_latency", c1 - c0, 2);
        check("stream_nlast", nlast, 2);
        check("stream_last_word", last_tlast_data, 16'h0008);
        drain(20);

        // Backpressure: 5-cycle stall mid-stream.
        for (int i = 9; i <= 16; i++) push(16'(i));
        nb = 0; k = 0;
        while (nb < 2 && k < 20) begin
            step();
            k++;
            if (s_pop) nb++;
        end
        m_tready = 1'b0;
        nrd = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_readp) nrd++;
            if (i >= 2) check("bp_readp_off", s_readp, 1'b0);
        end
        check("bp_reads_le2", (nrd <= 2), 1'b1);
        check("bp_buf_full", s_valid, 1'b1);
        m_tready = 1'b1;
        drain(30);

        // FIFO refill after a gap: burst position carries across.
        push(16'h0101); push(16'h0102); push(16'h0103);
        drain(20);
        for (int i = 0; i < 10; i++) step();
        check("gap_busy", s_busy, 1'b0);
        check("gap_valid", s_valid, 1'b0);
        push(16'h0201); push(16'h0202);
        drain(20);
        check("refill_last_word", last_tlast_data, 16'h0201);

        // en dropped right after a read: in-flight word still delivered.
        en = 1'b0;
        push(16'h0301); push(16'h0302); push(16'h0303); push(16'h0304);
        en = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!s_readp && k < 10);
        check("en_saw_read", s_readp, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("en_no_read", s_readp, 1'b0);
        end
        check("en_busy_low", s_busy, 1'b0);
        check("en_delivered", 4 - exp_q.size(), 1);
        en = 1'b1;
        drain(20);

        // Reset mid-operation with a full buffer.
        for (int i = 1; i <= 6; i++) push(16'h0400 + 16'(i));
        nb = 0; k = 0;
        while (nb < 1 && k < 20) begin
            step();
            k++;
            if (s_pop) nb++;
        end
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_valid", s_valid, 1'b1);
        rstp = 1'b1;
        step();
        check("rst_gates_readp", s_readp, 1'b0);
        rstp = 1'b0;
        fq.delete();
        exp_q.delete();
        mcnt = 0;
        fifo_emptyp = 1'b1;
        stall_prev = 1'b0;
        step();
        check("mid_rst_valid", s_valid, 1'b0);
        check("mid_rst_busy", s_busy, 1'b0);
        check("mid_rst_last", s_last, 1'b0);
        check("mid_rst_data", s_data, 16'h0000);
        m_tready = 1'b1;
        push(16'h0501); push(16'h0502); push(16'h0503); push(16'h0504);
        drain(20);
        check("post_rst_last_word", last_tlast_data, 16'h0504);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
